iterative_muldiv_unit: RTL and testbench
========================================

// Module: iterative_muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit next to the single-cycle ALU: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Radix-2 shift-add multiply and restoring divide, one result bit per clock, start/valid handshake.
//  Control stalls the core while busy=1. Width generalised via XLEN.
// PARAMETERS
//  XLEN       32  operand/result width (>=8, even)
//  EARLY_OUT  1   1: div-by-zero and signed overflow finish in one cycle; 0: take full XLEN cycles
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     async active-low reset
//  start         in   1     request; accepted only when busy=0
//  funct3        in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a          in   XLEN  rs1 value (multiplicand / dividend)
//  op_b          in   XLEN  rs2 value (multiplier / divisor)
//  flush         in   1     abort in-flight op (branch redirect)
//  busy          out  1     op accepted and not yet finished
//  result_valid  out  1     one-cycle pulse; result valid in this cycle
//  result        out  XLEN  result; holds its last value until the next completion
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, result_valid=0, result=0, count=0, all working regs 0.
//  FSM: IDLE -start-> CALC (or FIN on EARLY_OUT special case); CALC -count==XLEN-1-> FIN; FIN -> IDLE,
//   or straight to CALC/FIN if start=1 in FIN (back-to-back; start is accepted in FIN).
//  Accept edge: latch funct3; operands converted to magnitude with sign flags (signed: DIV,REM,MULH both;
//   MULHSU op_a only); count=0. busy=1 from the cycle after the accept edge through the last CALC cycle.
//  Latency: result_valid=1 exactly XLEN+1 cycles after the accept edge (special cases: 1 cycle).
//  start while busy=1: ignored, no side effect. funct3/op_a/op_b sampled on the accept edge only.
//  Multiply: 2*XLEN-bit product; MUL -> low XLEN bits, MULH/MULHSU/MULHU -> high XLEN bits;
//   negate the full 2*XLEN product when the sign flags differ, before slicing.
//  Divide: restoring, quotient/remainder in magnitude; quotient sign = sa^sb; remainder sign = sa.
//  Div by zero: quotient = all ones (DIV and DIVU); remainder = op_a unchanged.
//  Signed overflow (op_a=MIN, op_b=-1, DIV/REM): quotient=MIN, remainder=0.
//  EARLY_OUT=0: special cases still produce these values after the full latency.
//  flush: in CALC/FIN -> IDLE next edge, result_valid not asserted, result unchanged.
//   flush outranks start in the same cycle: no accept.
//  Mid-op reset: immediate IDLE, outputs to reset values; no pending result survives.
//  Counter width $clog2(XLEN); no wrap beyond XLEN-1.
// STRUCTURE
//  muldiv_pkg: funct3 localparams (F3_MUL..F3_REMU), state encoding (S_IDLE,S_CALC,S_FIN),
//   helper function is_signed_a/is_signed_b.
//  Sub-module muldiv_sign_fix (combinational): abs-value and conditional negate, parameter W;
//   instantiated for the operand path and the result path.
//  Single FSM plus a shared XLEN+1-bit adder/subtractor for both mul and div iterations.
// TESTING (XLEN=32, EARLY_OUT=1 unless noted)
//  MUL 7*6 -> result=0x0000002A, valid pulse 33 cycles after accept, busy high 32 cycles.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF;
//   MULHU same operands -> 0x00000001.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 13/0 -> 0xFFFFFFFF and REMU 13/0 -> 13, each valid 1 cycle after accept;
//   DIV 0x80000000/-1 -> 0x80000000, REM -> 0; repeat with EARLY_OUT=0 -> same values at 33 cycles.
//  Back-to-back: start held through FIN -> second op accepted on the FIN edge, two valid pulses 33 cycles apart;
//   start during CALC -> ignored.
//  flush at CALC cycle 10 -> IDLE, no valid pulse, result keeps old value;
//   rst_n low mid-CALC -> busy=0, result=0 asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used as abs() on operands and as
// sign restoration on the magnitude result.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one result bit per clock, sharing one adder.
module iterative_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int                CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   hi_q, lo_q, bmag_q, result_q;
    logic              sa_q, sb_q, div0_q, valid_q;

    logic              sa_in, sb_in, div0_in, ovf_in, special_in, accept;
    logic [XLEN-1:0]   amag, bmag;

    assign sa_in      = is_signed_a(funct3) & op_a[XLEN-1];
    assign sb_in      = is_signed_b(funct3) & op_b[XLEN-1];
    assign div0_in    = funct3[2] && (op_b == '0);
    assign ovf_in     = funct3[2] && !funct3[0] && (op_a == XMIN) && (op_b == '1);
    assign special_in = EARLY_OUT && (div0_in || ovf_in);
    assign accept     = start && !flush && (state_q == S_IDLE || state_q == S_FIN);

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val_i(op_a), .neg_i(sa_in), .val_o(amag));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val_i(op_b), .neg_i(sb_in), .val_o(bmag));

    // Shared adder: add multiplicand for mul, trial-subtract divisor for div.
    logic            is_mul_q, is_rem_q;
    logic [XLEN:0]   add_a, add_b, sum;

    assign is_mul_q = !f3_q[2];
    assign is_rem_q = f3_q[1];
    assign add_a    = is_mul_q ? {1'b0, hi_q} : {hi_q, lo_q[XLEN-1]};
    assign add_b    = is_mul_q ? {1'b0, bmag_q} : ~{1'b0, bmag_q};
    assign sum      = add_a + add_b + {{XLEN{1'b0}}, ~is_mul_q};

    // Result path: sign is restored on the full product before slicing.
    logic [2*XLEN-1:0] fix_in, fixed;
    logic              fix_neg;
    logic [XLEN-1:0]   final_res;

    assign fix_in  = is_mul_q ? {hi_q, lo_q} : {{XLEN{1'b0}}, (is_rem_q ? hi_q : lo_q)};
    assign fix_neg = (is_mul_q || !is_rem_q) ? (sa_q ^ sb_q) : sa_q;

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_res (.val_i(fix_in), .neg_i(fix_neg), .val_o(fixed));

    always_comb begin
        final_res = fixed[XLEN-1:0];
        if (is_mul_q) begin
            if (f3_q != F3_MUL) final_res = fixed[2*XLEN-1:XLEN];
        end else if (div0_q && !is_rem_q) begin
            final_res = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special_in ? S_FIN : S_CALC;
            S_CALC: begin
                if (flush)                      state_d = S_IDLE;
                else if (count_q == CNT_LAST)   state_d = S_FIN;
            end
            S_FIN: begin
                if (accept) state_d = special_in ? S_FIN : S_CALC;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == S_CALC);
        result_valid = valid_q;
        result       = result_q;
    end

    // Early-out div-by-zero preloads the remainder with |op_a| so the result path restores op_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            f3_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            bmag_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                f3_q    <= funct3;
                sa_q    <= sa_in;
                sb_q    <= sb_in;
                div0_q  <= div0_in;
                bmag_q  <= bmag;
                lo_q    <= amag;
                hi_q    <= (special_in && div0_in) ? amag : '0;
                count_q <= '0;
            end else if (state_q == S_CALC) begin
                count_q <= (count_q == CNT_LAST) ? count_q : count_q + CNT_W'(1);
                if (is_mul_q) begin
                    if (lo_q[0]) {hi_q, lo_q} <= {sum, lo_q[XLEN-1:1]};
                    else         {hi_q, lo_q} <= {1'b0, hi_q, lo_q[XLEN-1:1]};
                end else begin
                    hi_q <= sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], ~sum[XLEN]};
                end
            end
            valid_q <= (state_q == S_FIN) && !flush;
            if ((state_q == S_FIN) && !flush) result_q <= final_res;
        end
    end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Bench for iterative_muldiv_unit: EARLY_OUT=1 and EARLY_OUT=0 instances on shared
// inputs, a per-instance timeline/arithmetic model, directed and random stimulus.
module tb_iterative_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [1:0]  busy_w, valid_w;
    logic [31:0] res_w [2];

    always #5 clk = ~clk;

    iterative_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut_eo (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .busy(busy_w[0]), .result_valid(valid_w[0]), .result(res_w[0]));

    iterative_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .busy(busy_w[1]), .result_valid(valid_w[1]), .result(res_w[1]));

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa64, sb64, ua64, ub64, p;
        int ai, bi;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        ai = a;
        bi = b;
        p = 64'd0;
        case (f)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ai / bi);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ai % bi);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    // Timeline model: an op accepted at edge c reports at edge c+lat; a new op may be
    // accepted on that same edge; flush drops whatever is in flight.
    bit          m_pend [2] = '{1'b0, 1'b0};
    bit          m_full [2] = '{1'b0, 1'b0};
    bit          m_valid[2] = '{1'b0, 1'b0};
    bit          m_busy [2] = '{1'b0, 1'b0};
    int          m_left [2] = '{0, 0};
    logic [31:0] m_pres [2] = '{32'd0, 32'd0};
    logic [31:0] m_res  [2] = '{32'd0, 32'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 1'b0; m_full[i] = 1'b0; m_valid[i] = 1'b0;
                m_busy[i] = 1'b0; m_left[i] = 0; m_pres[i] = 32'd0; m_res[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0;
                if (m_pend[i]) m_left[i]--;
                if (flush) begin
                    m_pend[i] = 1'b0;
                end else begin
                    if (m_pend[i] && m_left[i] == 0) begin
                        m_valid[i] = 1'b1;
                        m_res[i]   = m_pres[i];
                        m_pend[i]  = 1'b0;
                    end
                    if (start && !m_pend[i]) begin
                        m_pend[i] = 1'b1;
                        m_full[i] = !(i == 0 && is_special(funct3, op_a, op_b));
                        m_left[i] = m_full[i] ? 33 : 1;
                        m_pres[i] = ref_op(funct3, op_a, op_b);
                    end
                end
                m_busy[i] = m_pend[i] && m_full[i] && (m_left[i] >= 2);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk((i == 0) ? "valid_eo" : "valid_full", 64'(valid_w[i]), 64'(m_valid[i]));
                chk((i == 0) ? "busy_eo" : "busy_full", 64'(busy_w[i]), 64'(m_busy[i]));
                chk((i == 0) ? "result_eo" : "result_full", 64'(res_w[i]), 64'(m_res[i]));
            end
        end
    end

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat_eo, input int lat_full);
        int got[2];
        logic [31:0] r[2];
        int bc;
        got = '{-1, -1};
        r = '{32'd0, 32'd0};
        bc = 0;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
            end
            if (busy_w[0]) bc++;
            for (int i = 0; i < 2; i++)
                if (valid_w[i] && got[i] < 0) begin got[i] = k; r[i] = res_w[i]; end
        end
        chk({nm, "_res_eo"}, 64'(r[0]), 64'(exp));
        chk({nm, "_res_full"}, 64'(r[1]), 64'(exp));
        chk({nm, "_lat_eo"}, 64'(got[0]), 64'(lat_eo));
        chk({nm, "_lat_full"}, 64'(got[1]), 64'(lat_full));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'((lat_eo == 1) ? 0 : 32));
    endtask

    initial begin
        int cnt;
        int t[2];
        int nv;
        logic [31:0] r2;
        rst_n = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 64'(busy_w[0]), 64'd0);
        chk("reset_valid", 64'(valid_w[0]), 64'd0);
        chk("reset_result", 64'(res_w[0]), 64'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("model_mulhsu", 64'(ref_op(3'd2, 32'hFFFF_FFFF, 32'd2)), 64'hFFFF_FFFF);
        chk("model_rem", 64'(ref_op(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
        chk("model_divovf", 64'(ref_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);

        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 33);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 33, 33);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 33);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33, 33);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33, 33);
        run_op("divu0",  3'd5, 32'd13,        32'd0,         32'hFFFF_FFFF, 1,  33);
        run_op("remu0",  3'd7, 32'd13,        32'd0,         32'd13,        1,  33);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  33);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  33);
        run_op("mul",    3'd0, 32'd7,         32'd6,         32'h0000_002A, 33, 33);

        // Flush at CALC cycle 10: no pulse, previous result kept.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_w != 2'b00) cnt++;
        end
        chk("flush_no_valid", 64'(cnt), 64'd0);
        chk("flush_hold_eo", 64'(res_w[0]), 64'h2A);
        chk("flush_hold_full", 64'(res_w[1]), 64'h2A);

        // Flush outranks start.
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 64'(busy_w), 64'd0);
        repeat (3) @(negedge clk);

        // Back-to-back: start held through FIN, operand change during CALC must not matter.
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'd6;
        t = '{-100, -100};
        nv = 0;
        r2 = 32'd0;
        for (int k = 0; k < 76; k++) begin
            @(negedge clk);
            if (k == 10) op_a = 32'd9;
            if (k == 34) start = 1'b0;
            if (valid_w[0] && nv < 2) begin t[nv] = k; r2 = res_w[0]; nv++; end
        end
        chk("b2b_first_lat", 64'(t[0]), 64'd33);
        chk("b2b_gap", 64'(t[1] - t[0]), 64'd33);
        chk("b2b_second_res", 64'(r2), 64'd54);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy_w), 64'd0);
        chk("midreset_result", 64'(res_w[0]), 64'd0);
        chk("midreset_valid", 64'(valid_w), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start  = ($urandom % 4) == 0;
            flush  = ($urandom % 64) == 0;
            funct3 = 3'($urandom);
            op_a   = pick();
            op_b   = pick();
        end
        start = 1'b0; flush = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
